// File: rtl/posit_sched_pkg.sv
// Shared types and defaults for the posit dot-product scheduler.
// FSM encodings and the default datapath geometry.
package posit_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } sched_st_e;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_K       = 9;
  localparam int unsigned DEF_ADDR_W  = 10;
  localparam int unsigned DEF_NOUT_W  = 8;
  localparam int unsigned DEF_TMO_CYC = 32;

endpackage

// File: rtl/posit_sched_agen.sv
// Operand address generator: beat counter and running row base.
// Addresses are forced to zero whenever no read is issued.
module posit_sched_agen
  import posit_sched_pkg::*;
#(
  parameter int unsigned K      = DEF_K,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rstn,
  input  logic              load,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] d_base,
  input  logic              issue,
  input  logic              advance,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] d_addr,
  output logic              last_beat
);

  localparam int unsigned IW =
    (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] I_LAST =
    IW'(K - 1);
  localparam logic [ADDR_W-1:0] K_STEP =
    ADDR_W'(K);

  logic [IW-1:0]     beat;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] dbase;

  assign last_beat = issue && (beat == I_LAST);

  assign w_addr = issue ? row + ADDR_W'(beat)
                        : '0;
  assign d_addr = issue ? dbase + ADDR_W'(beat)
                        : '0;

  // Beat index per product; row base steps by K per finished product.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      beat  <= '0;
      row   <= '0;
      dbase <= '0;
    end else if (load) begin
      beat  <= '0;
      row   <= w_base;
      dbase <= d_base;
    end else begin
      if (issue)
        beat <= last_beat ? '0 : beat + IW'(1);
      if (advance)
        row <= row + K_STEP;
    end
  end

endmodule

// File: rtl/posit_dot_sched.sv
// Posit MAC sequencer: issue K operand reads, await result, hand off.
// Optional watchdog on the MAC wait: define POSIT_SCHED_TMO_EN.
module posit_dot_sched
  import posit_sched_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned K       = DEF_K,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned NOUT_W  = DEF_NOUT_W,
  parameter int unsigned TMO_CYC = DEF_TMO_CYC
) (
  input  logic              clk_i,
  input  logic              rstn,
  input  logic              start_i,
  input  logic [NOUT_W-1:0] n_out_i,
  input  logic [ADDR_W-1:0] w_base_i,
  input  logic [ADDR_W-1:0] d_base_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              w_rd_o,
  output logic [ADDR_W-1:0] w_addr_o,
  input  logic [WIDTH-1:0]  w_data_i,
  output logic              d_rd_o,
  output logic [ADDR_W-1:0] d_addr_o,
  input  logic [WIDTH-1:0]  d_data_i,
  output logic              mac_vld_o,
  output logic [WIDTH-1:0]  mac_win_o,
  output logic [WIDTH-1:0]  mac_din_o,
  input  logic [WIDTH-1:0]  mac_acc_i,
  input  logic              mac_vld_i,
  output logic              res_vld_o,
  output logic [WIDTH-1:0]  res_data_o,
  output logic [NOUT_W-1:0] res_idx_o,
  input  logic              res_rdy_i
);

  sched_st_e state;
  sched_st_e state_nx;

  logic [NOUT_W-1:0] n_out;
  logic [NOUT_W-1:0] j;
  logic [WIDTH-1:0]  res_data;
  logic [NOUT_W-1:0] res_idx;
  logic              done_q;
  logic              mac_vld_q;

  logic accept;
  logic load;
  logic issue;
  logic last_beat;
  logic res_take;
  logic hshake;
  logic last_prod;
  logic tmo_hit;

  assign accept    = (state == IDLE) && start_i;
  assign load      = accept && (n_out_i != '0);
  assign issue     = (state == ISSUE);
  assign res_take  = (state == WAIT) && mac_vld_i;
  assign hshake    = (state == OUT) && res_rdy_i;
  assign last_prod = (j + NOUT_W'(1)) == n_out;

  posit_sched_agen #(
    .K      (K),
    .ADDR_W (ADDR_W)
  ) u_agen (
    .clk_i     (clk_i),
    .rstn      (rstn),
    .load      (load),
    .w_base    (w_base_i),
    .d_base    (d_base_i),
    .issue     (issue),
    .advance   (hshake),
    .w_addr    (w_addr_o),
    .d_addr    (d_addr_o),
    .last_beat (last_beat)
  );

`ifdef POSIT_SCHED_TMO_EN
  localparam int unsigned TW =
    ($clog2(TMO_CYC + 1) > 6) ?
    $clog2(TMO_CYC + 1) : 6;

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  // Abort when the MAC stays silent for TMO_CYC WAIT cycles.
  assign tmo_hit = (state == WAIT) && !mac_vld_i &&
                   (tmo_cnt == TW'(TMO_CYC - 1));
  assign err_o   = err_q;

  // Wait-cycle counter and sticky abort flag.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (state == WAIT) ?
                 tmo_cnt + TW'(1) : '0;
      if (accept)
        err_q <= 1'b0;
      else if (tmo_hit)
        err_q <= 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign unused_tmo = (TMO_CYC != 0);
  assign tmo_hit    = 1'b0;
  assign err_o      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (load)
          state_nx = ISSUE;
      ISSUE:
        if (last_beat)
          state_nx = WAIT;
      WAIT:
        if (mac_vld_i)
          state_nx = OUT;
        else if (tmo_hit)
          state_nx = IDLE;
      OUT:
        if (res_rdy_i)
          state_nx = last_prod ? IDLE : ISSUE;
      default:
        state_nx = IDLE;
    endcase
  end

  // Job bookkeeping, result capture, done and MAC-valid pipelining.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      n_out     <= '0;
      j         <= '0;
      res_data  <= '0;
      res_idx   <= '0;
      done_q    <= 1'b0;
      mac_vld_q <= 1'b0;
    end else begin
      done_q    <= (accept && (n_out_i == '0)) ||
                   (hshake && last_prod) ||
                   tmo_hit;
      mac_vld_q <= issue;
      if (load) begin
        n_out <= n_out_i;
        j     <= '0;
      end else if (hshake) begin
        j <= j + NOUT_W'(1);
      end
      if (res_take) begin
        res_data <= mac_acc_i;
        res_idx  <= j;
      end
    end
  end

  assign busy_o     = (state != IDLE);
  assign done_o     = done_q;
  assign w_rd_o     = issue;
  assign d_rd_o     = issue;
  assign mac_vld_o  = mac_vld_q;
  assign mac_win_o  = w_data_i;
  assign mac_din_o  = d_data_i;
  assign res_vld_o  = (state == OUT);
  assign res_data_o = res_data;
  assign res_idx_o  = res_idx;

endmodule

// File: tb/tb_posit_dot_sched.sv
// Randomized bench for posit_dot_sched with memory/MAC models.
// Expected addresses and dot products come from a reference model.
module tb_posit_dot_sched;

  localparam int WIDTH   = 8;
  localparam int K       = 9;
  localparam int ADDR_W  = 10;
  localparam int NOUT_W  = 8;
  localparam int TMO_CYC = 32;
  localparam int MSZ     = 1 << ADDR_W;

  logic              clk_i = 1'b0;
  logic              rstn  = 1'b0;
  logic              start_i = 1'b0;
  logic [NOUT_W-1:0] n_out_i = '0;
  logic [ADDR_W-1:0] w_base_i = '0;
  logic [ADDR_W-1:0] d_base_i = '0;
  logic              busy_o, done_o, err_o;
  logic              w_rd_o, d_rd_o;
  logic [ADDR_W-1:0] w_addr_o, d_addr_o;
  logic [WIDTH-1:0]  w_data_i = '0;
  logic [WIDTH-1:0]  d_data_i = '0;
  logic              mac_vld_o;
  logic [WIDTH-1:0]  mac_win_o, mac_din_o;
  logic [WIDTH-1:0]  mac_acc_i = '0;
  logic              mac_vld_i = 1'b0;
  logic              res_vld_o;
  logic [WIDTH-1:0]  res_data_o;
  logic [NOUT_W-1:0] res_idx_o;
  logic              res_rdy_i = 1'b0;

  posit_dot_sched #(
    .WIDTH(WIDTH), .K(K), .ADDR_W(ADDR_W),
    .NOUT_W(NOUT_W), .TMO_CYC(TMO_CYC)
  ) dut (
    .clk_i(clk_i), .rstn(rstn),
    .start_i(start_i), .n_out_i(n_out_i),
    .w_base_i(w_base_i), .d_base_i(d_base_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .w_rd_o(w_rd_o), .w_addr_o(w_addr_o),
    .w_data_i(w_data_i),
    .d_rd_o(d_rd_o), .d_addr_o(d_addr_o),
    .d_data_i(d_data_i),
    .mac_vld_o(mac_vld_o), .mac_win_o(mac_win_o),
    .mac_din_o(mac_din_o), .mac_acc_i(mac_acc_i),
    .mac_vld_i(mac_vld_i),
    .res_vld_o(res_vld_o), .res_data_o(res_data_o),
    .res_idx_o(res_idx_o), .res_rdy_i(res_rdy_i)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0] wmem [MSZ];
  logic [7:0] dmem [MSZ];

  int n_cmp = 0;
  int n_bad = 0;

  // environment knobs
  int lat = 12;
  int rmode = 0;
  int stall_left = 0;
  bit stray_en = 0;
  bit mac_en = 1;

  // monitor logs
  logic [31:0] wq[$];
  logic [31:0] dq[$];
  logic [31:0] rq[$];
  logic [31:0] iq[$];
  int cyc = 0;
  int done_cnt, done_cyc, last_mv_cyc;
  int mv_cnt, mv_mis, rd_mis, hold_err;
  int rd_in_out, run_len, run_bad;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int ref_dot(int wb, int db,
                                 int p);
    int s = 0;
    for (int i = 0; i < K; i++)
      s += int'(wmem[(wb + K * p + i) % MSZ]) *
           int'(dmem[(db + i) % MSZ]);
    return s & 255;
  endfunction

  // Sync operand memories and a MAC with configurable latency.
  initial begin : env
    bit rd_q = 0;
    int wa_q = 0, da_q = 0;
    int beats = 0, acc = 0, res = 0, due = 0;
    bit pend = 0;
    int ec = 0;
    forever begin
      @(posedge clk_i); #1;
      if (rd_q) begin
        w_data_i = wmem[wa_q];
        d_data_i = dmem[da_q];
      end
      rd_q = w_rd_o;
      wa_q = int'(w_addr_o);
      da_q = int'(d_addr_o);
      #1;
      mac_vld_i = 1'b0;
      if (!rstn) begin
        beats = 0; acc = 0; pend = 0;
      end else begin
        if (mac_vld_o) begin
          acc = (acc + int'(mac_win_o) *
                 int'(mac_din_o)) & 255;
          beats++;
          if (beats == K) begin
            pend = 1; due = ec + lat;
            res = acc; acc = 0; beats = 0;
          end
        end
        if (pend && ec == due) begin
          pend = 0;
          if (mac_en) begin
            mac_vld_i = 1'b1;
            mac_acc_i = 8'(res);
          end
        end else if (stray_en && res_vld_o &&
                     $urandom_range(0, 2) == 0) begin
          mac_vld_i = 1'b1;
          mac_acc_i = 8'($urandom);
        end
      end
      ec++;
    end
  end

  // Result consumer: always ready, random, or a 20-cycle stall.
  initial begin : cons
    forever begin
      @(posedge clk_i); #1;
      if (rmode == 0)
        res_rdy_i = 1'b1;
      else if (rmode == 1)
        res_rdy_i = 1'($urandom_range(0, 1));
      else if (res_vld_o && stall_left > 0) begin
        res_rdy_i = 1'b0;
        stall_left--;
      end else
        res_rdy_i = 1'b1;
    end
  end

  // Observer, sampled mid-cycle.
  initial begin : mon
    bit prev_rd = 0, prev_vld = 0, prev_rdy = 0;
    logic [7:0] prev_data = '0;
    logic [7:0] prev_idx = '0;
    forever begin
      @(negedge clk_i);
      if (!rstn) begin
        prev_rd = 0; prev_vld = 0;
        prev_rdy = 0; run_len = 0;
      end else begin
        if (w_rd_o) begin
          wq.push_back(32'(w_addr_o));
          dq.push_back(32'(d_addr_o));
          run_len++;
          if (res_vld_o) rd_in_out++;
        end else if (run_len != 0) begin
          if (run_len != K) run_bad++;
          run_len = 0;
        end
        if (d_rd_o !== w_rd_o) rd_mis++;
        if (mac_vld_o !== prev_rd) mv_mis++;
        if (mac_vld_o) begin
          mv_cnt++;
          last_mv_cyc = cyc;
        end
        if (res_vld_o && prev_vld && !prev_rdy &&
            (res_data_o !== prev_data ||
             res_idx_o !== prev_idx))
          hold_err++;
        if (res_vld_o && res_rdy_i) begin
          rq.push_back(32'(res_data_o));
          iq.push_back(32'(res_idx_o));
        end
        if (done_o) begin
          done_cnt++;
          done_cyc = cyc;
        end
        prev_rd = w_rd_o;
        prev_vld = res_vld_o;
        prev_rdy = res_rdy_i;
        prev_data = res_data_o;
        prev_idx = res_idx_o;
      end
      cyc++;
    end
  end

  task automatic clear_logs();
    wq.delete(); dq.delete();
    rq.delete(); iq.delete();
    done_cnt = 0; mv_cnt = 0; mv_mis = 0;
    rd_mis = 0; hold_err = 0;
    rd_in_out = 0; run_bad = 0;
  endtask

  // Launch a job and wait (bounded) for done plus a short tail.
  task automatic launch(input int n, input int wb,
                        input int db, input bit noise);
    int t = 0;
    bit inj = 0;
    clear_logs();
    start_i = 1'b1;
    n_out_i = NOUT_W'(n);
    w_base_i = ADDR_W'(wb);
    d_base_i = ADDR_W'(db);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n_out_i = NOUT_W'($urandom);
    w_base_i = ADDR_W'($urandom);
    d_base_i = ADDR_W'($urandom);
    chk("busy_after_start", 32'(busy_o),
        32'(n != 0));
    while (done_cnt == 0 && t < 400 * n + 200) begin
      start_i = 1'b0;
      if (noise && !inj && w_rd_o) begin
        start_i = 1'b1;
        n_out_i = NOUT_W'(5);
        inj = 1;
      end
      @(posedge clk_i); #1;
      t++;
    end
    start_i = 1'b0;
    if (done_cnt == 0)
      chk("done_timeout", 32'(t), 32'(0));
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic run_job(input int n, input int wb,
                         input int db, input int l,
                         input int rm, input bit noise);
    int k;
    lat = l;
    rmode = rm;
    stall_left = (rm == 2) ? 20 : 0;
    stray_en = noise;
    launch(n, wb, db, noise);
    stray_en = 0;
    chk("rd_count", 32'(wq.size()), 32'(n * K));
    for (int p = 0; p < n; p++)
      for (int i = 0; i < K; i++) begin
        k = p * K + i;
        if (k < wq.size()) begin
          chk("w_addr", wq[k],
              32'((wb + K * p + i) % MSZ));
          chk("d_addr", dq[k],
              32'((db + i) % MSZ));
        end
      end
    chk("res_count", 32'(rq.size()), 32'(n));
    for (int p = 0; p < n; p++)
      if (p < rq.size()) begin
        chk("res_idx", iq[p], 32'(p));
        chk("res_data", rq[p],
            32'(ref_dot(wb, db, p)));
      end
    chk("done_count", 32'(done_cnt), 32'(1));
    chk("mac_beats", 32'(mv_cnt), 32'(n * K));
    chk("mac_vld_align", 32'(mv_mis), 32'(0));
    chk("rd_burst", 32'(run_bad), 32'(0));
    chk("d_rd_eq_w_rd", 32'(rd_mis), 32'(0));
    chk("res_hold", 32'(hold_err), 32'(0));
    chk("rd_during_out", 32'(rd_in_out), 32'(0));
    chk("busy_end", 32'(busy_o), 32'(0));
    chk("err_clear", 32'(err_o), 32'(0));
    if (rm == 2)
      chk("stall_used", 32'(stall_left), 32'(0));
  endtask

  task automatic chk_quiet(input string pfx);
    chk({pfx, "_busy"}, 32'(busy_o), 32'(0));
    chk({pfx, "_done"}, 32'(done_o), 32'(0));
    chk({pfx, "_err"}, 32'(err_o), 32'(0));
    chk({pfx, "_w_rd"}, 32'(w_rd_o), 32'(0));
    chk({pfx, "_mac_vld"}, 32'(mac_vld_o), 32'(0));
    chk({pfx, "_res_vld"}, 32'(res_vld_o), 32'(0));
  endtask

  initial begin : main
    for (int a = 0; a < MSZ; a++) begin
      wmem[a] = 8'($urandom);
      dmem[a] = 8'($urandom);
    end
    repeat (3) @(posedge clk_i);
    #1;
    chk_quiet("reset");
    chk("reset_res_data", 32'(res_data_o), 32'(0));
    chk("reset_res_idx", 32'(res_idx_o), 32'(0));
    chk("reset_w_addr", 32'(w_addr_o), 32'(0));
    rstn = 1'b1;
    @(posedge clk_i); #1;
    chk_quiet("post_reset");

    run_job(1, 'h10, 'h80, 12, 0, 0);
    run_job(3, 'h40, 'h200, 12, 0, 0);
    run_job(2, 'h123, 'h2F0, 5, 2, 0);
    run_job(2, MSZ - 4, MSZ - 3, 3, 0, 0);
    run_job(3, 'h3A0, 'h011, 7, 1, 1);

    // Empty job: done only, no reads.
    launch(0, 'h55, 'h66, 0);
    chk("n0_done", 32'(done_cnt), 32'(1));
    chk("n0_reads", 32'(wq.size()), 32'(0));

    for (int r = 0; r < 6; r++)
      run_job($urandom_range(1, 4),
              $urandom_range(0, MSZ - 1),
              $urandom_range(0, MSZ - 1),
              $urandom_range(2, 14),
              $urandom_range(0, 2),
              1'($urandom_range(0, 1)));

`ifdef POSIT_SCHED_TMO_EN
    mac_en = 0;
    rmode = 0;
    launch(1, 'h20, 'h30, 0);
    chk("tmo_done", 32'(done_cnt), 32'(1));
    chk("tmo_err", 32'(err_o), 32'(1));
    chk("tmo_delay", 32'(done_cyc - last_mv_cyc),
        32'(TMO_CYC));
    chk("tmo_no_res", 32'(rq.size()), 32'(0));
    mac_en = 1;
    run_job(2, 'h20, 'h30, 6, 0, 0);
`endif

    // Asynchronous reset in the middle of a job.
    lat = 12;
    rmode = 0;
    clear_logs();
    start_i = 1'b1;
    n_out_i = NOUT_W'(4);
    w_base_i = ADDR_W'('h100);
    d_base_i = ADDR_W'('h180);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (14) @(posedge clk_i);
    #3;
    rstn = 1'b0;
    #1;
    chk_quiet("midjob_reset");
    @(posedge clk_i); #1;
    rstn = 1'b1;
    chk("midjob_no_done", 32'(done_cnt), 32'(0));
    run_job(2, 'h300, 'h310, 4, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
